// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, iterated LSB-first over WIDTH clocks.
// Operands load on start; sum/cout are registered and published with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Returns {carry, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [1:0]       w_fa;
  logic             w_last;
  logic             w_load;

  assign w_fa   = full_add(r_sa[0], r_sb[0], r_c);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a start in DONE is accepted just like in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_load      = 1'b0;
      end
    endcase
  end

  // Datapath: operand load, per-bit shift, and result capture on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_ss   <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_sa   <= a;
        r_sb   <= b;
        r_c    <= cin;
        r_cnt  <= '0;
        r_ss   <= '0;
        r_busy <= 1'b1;
      end else if (r_state == ST_SHIFT) begin
        r_ss  <= {w_fa[0], r_ss[WIDTH-1:1]};
        r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
        r_c   <= w_fa[1];
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_sum  <= {w_fa[0], r_ss[WIDTH-1:1]};
          r_cout <= w_fa[1];
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios, randomized ops and an exhaustive 4-bit sweep.
// Expected results come from plain integer addition of the applied operands.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CNT_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // Pulse start for one edge; returns at the negedge right after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Counts edges after acceptance until done is seen, plus samples with busy high.
  task automatic wait_done8(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) begin
      $display("FAIL timeout8 waiting for done: waited %0d cycles, required < 40", cyc);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      $display("FAIL reset_state8: got busy=%b done=%b cout=%b sum=%h, required all 0", busy8, done8, cout8, sum8);
      errors++;
    end
    checks++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      $display("FAIL reset_state4: got busy=%b done=%b cout=%b sum=%h, required all 0", busy4, done4, cout4, sum4);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_in();
    int cyc, bc;
    start_op8(8'h5A, 8'hA5, 1'b1);
    wait_done8(cyc, bc);
    checks++;
    if ({cout8, sum8} !== 9'h100) begin
      $display("FAIL carry_in_1: got cout=%b sum=%h, required cout=1 sum=00", cout8, sum8);
      errors++;
    end
    start_op8(8'h5A, 8'hA5, 1'b0);
    wait_done8(cyc, bc);
    checks++;
    if ({cout8, sum8} !== 9'h0FF) begin
      $display("FAIL carry_in_0: got cout=%b sum=%h, required cout=0 sum=FF", cout8, sum8);
      errors++;
    end
  endtask

  task automatic test_reset_midop();
    int cyc, bc;
    logic saw_done;
    start_op8(8'h3C, 8'h42, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      $display("FAIL reset_async: got busy=%b done=%b cout=%b sum=%h, required all 0", busy8, done8, cout8, sum8);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      $display("FAIL reset_discard: got stray busy/done=%b after reset, required 0", saw_done);
      errors++;
    end
    start_op8(8'h3C, 8'h42, 1'b0);
    wait_done8(cyc, bc);
    checks++;
    if (cyc !== 8 || {cout8, sum8} !== 9'h07E) begin
      $display("FAIL reset_restart: got cyc=%0d cout=%b sum=%h, required cyc=8 cout=0 sum=7E", cyc, cout8, sum8);
      errors++;
    end
  endtask

  task automatic test_carry_ripple();
    int cyc, bc;
    start_op8(8'hFF, 8'h01, 1'b0);
    wait_done8(cyc, bc);
    checks++;
    if ({cout8, sum8} !== 9'h100 || cyc !== 8) begin
      $display("FAIL ripple_result: got cyc=%0d cout=%b sum=%h, required cyc=8 cout=1 sum=00", cyc, cout8, sum8);
      errors++;
    end
    checks++;
    if (bc !== 8) begin
      $display("FAIL ripple_busy: got busy for %0d cycles, required 8", bc);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      $display("FAIL ripple_done_width: got done=%b busy=%b next cycle, required 0/0", done8, busy8);
      errors++;
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, done_cyc;
    logic hold_bad;
    ndone = 0; done_cyc = -1; hold_bad = 1'b0;
    start_op8(8'h10, 8'h20, 1'b0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 4) begin
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8 === 1'b1) begin
        ndone++;
        done_cyc = cyc;
        checks++;
        if ({cout8, sum8} !== 9'h030) begin
          $display("FAIL busy_ignore_result: got cout=%b sum=%h, required cout=0 sum=30", cout8, sum8);
          errors++;
        end
      end else if (ndone == 0 && {cout8, sum8} !== 9'h100) begin
        hold_bad = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || done_cyc !== 8) begin
      $display("FAIL busy_ignore_pulses: got %0d done pulses (first at %0d), required 1 at 8", ndone, done_cyc);
      errors++;
    end
    checks++;
    if (hold_bad !== 1'b0) begin
      $display("FAIL busy_hold_prev: got previous result disturbed=%b, required 0", hold_bad);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [8:0] r1, r2;
    d1 = -1; d2 = -1; r1 = 9'h000; r2 = 9'h000;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (done8 === 1'b1) begin
        if (d1 < 0) begin
          d1 = cyc; r1 = {cout8, sum8};
          a8 = 8'h80; b8 = 8'h80;
        end else begin
          d2 = cyc; r2 = {cout8, sum8};
          start8 = 1'b0;
        end
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    checks++;
    if (d1 !== 8 || d2 !== 17) begin
      $display("FAIL b2b_timing: got done at %0d and %0d, required 8 and 17", d1, d2);
      errors++;
    end
    checks++;
    if (r1 !== 9'h002 || r2 !== 9'h100) begin
      $display("FAIL b2b_results: got %h then %h, required 002 then 100", r1, r2);
      errors++;
    end
    checks++;
    if (busy8 !== 1'b0) begin
      $display("FAIL b2b_idle: got busy=%b after start dropped, required 0", busy8);
      errors++;
    end
  endtask

  task automatic test_random();
    int cyc, bc;
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] exp;
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      start_op8(ra, rb, rc);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      wait_done8(cyc, bc);
      checks++;
      if ({cout8, sum8} !== exp || cyc !== 8) begin
        $display("FAIL random_op: a=%h b=%h cin=%b got cyc=%0d {cout,sum}=%h, required cyc=8 %h",
                 ra, rb, rc, cyc, {cout8, sum8}, exp);
        errors++;
      end
    end
  endtask

  task automatic test_exhaustive4();
    int cyc;
    logic [4:0] exp;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp = 5'(ia + ib + ic);
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          cyc = 0;
          while (done4 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
          end
          checks++;
          if ({cout4, sum4} !== exp || cyc !== 4) begin
            $display("FAIL exhaustive4: a=%0d b=%0d cin=%0d got cyc=%0d {cout,sum}=%0d, required cyc=4 %0d",
                     ia, ib, ic, cyc, {cout4, sum4}, exp);
            errors++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_in();
    test_reset_midop();
    test_carry_ripple();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_exhaustive4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
